// File: rtl/io_port_ctrl.sv
// io_port_ctrl: switch-bank reads held by a confirm button, and double-dabble BCD display of written values.
// Define IO_DEBOUNCE_EN to require DEBOUNCE stable cycles on the button before a capture.
module io_port_ctrl #(
    parameter int DATA_W   = 32,
    parameter int IN_W     = 4,
    parameter int N_IN     = 2,
    parameter int DIGITS   = 3,
    parameter int DEBOUNCE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           io_ctrl,
    input  logic [DATA_W-1:0]    io_addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [N_IN*IN_W-1:0] sw_in,
    input  logic                 btn_in,
    output logic [DATA_W-1:0]    rdata,
    output logic                 io_stall,
    output logic [DIGITS*4-1:0]  bcd,
    output logic                 disp_busy,
    output logic                 disp_ovf
);
    localparam int CW = $clog2(DATA_W);
    localparam int BW = DIGITS * 4;

    function automatic logic [63:0] pow10(input int n);
        pow10 = 64'd1;
        for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
    endfunction

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
        add3 = a;
        for (int i = 0; i < DIGITS; i++)
            add3[i*4 +: 4] = (a[i*4 +: 4] >= 4'd5) ? a[i*4 +: 4] + 4'd3 : a[i*4 +: 4];
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    if (DEBOUNCE < 1 || N_IN < 1 || DATA_W <= IN_W || DATA_W > 64) begin : g_param_check
        $error("io_port_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, WAIT_BTN, DONE} rd_state_t;
    typedef enum logic {D_IDLE, D_CONV} disp_state_t;

    logic [1:0] sync_q;
    logic       btn_s, btn_evt;
    assign btn_s = sync_q[1];

`ifdef IO_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE + 2);
    logic [DBW-1:0] db_q, db_d;
    // Saturating one past DEBOUNCE makes the event a single pulse per press.
    assign db_d    = !btn_s ? '0 : (db_q > DBW'(DEBOUNCE) ? db_q : db_q + DBW'(1));
    assign btn_evt = db_q == DBW'(DEBOUNCE);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) db_q <= '0;
        else        db_q <= db_d;
`else
    logic btn_prev_q;
    assign btn_evt = btn_s & ~btn_prev_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) btn_prev_q <= 1'b0;
        else        btn_prev_q <= btn_s;
`endif

    rd_state_t         rd_q, rd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, sel;
    logic [IN_W-1:0]   bank;
    logic              stall;

    assign sel = io_addr % DATA_W'(N_IN);

    always_comb begin
        bank = '0;
        for (int k = 0; k < N_IN; k++)
            if (sel == DATA_W'(k)) bank = sw_in[k*IN_W +: IN_W];
    end

    always_comb begin
        rd_d    = rd_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        case (rd_q)
            IDLE: begin
                stall = io_ctrl == 2'b10;
                rd_d  = stall ? WAIT_BTN : IDLE;
            end
            WAIT_BTN: begin
                stall = 1'b1;
                if (io_ctrl != 2'b10) rd_d = IDLE;
                else if (btn_evt) begin
                    rdata_d = DATA_W'(bank);
                    rd_d    = DONE;
                end
            end
            default: rd_d = IDLE;
        endcase
    end

    // Gated by rst_n so the stall drops the instant reset asserts.
    assign io_stall = stall & rst_n;
    assign rdata    = rdata_q;

    disp_state_t       disp_q, disp_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     acc_q, acc_d, bcd_q, bcd_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        disp_d  = disp_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        adj     = add3(acc_q);
        if (disp_q == D_CONV) begin
            {acc_d, shift_d} = {adj, shift_q} << 1;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_W - 1)) begin
                bcd_d  = acc_d;
                disp_d = D_IDLE;
            end
        end
        if (io_ctrl == 2'b01) begin
            ovf_d   = 64'(wdata) >= LIMIT;
            shift_d = wdata;
            acc_d   = '0;
            cnt_d   = '0;
            bcd_d   = ovf_d ? '1 : bcd_q;
            disp_d  = ovf_d ? D_IDLE : D_CONV;
        end
    end

    assign bcd       = bcd_q;
    assign disp_busy = disp_q == D_CONV;
    assign disp_ovf  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            rd_q    <= IDLE;
            rdata_q <= '0;
            disp_q  <= D_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_in};
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            disp_q  <= disp_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed checks of the read handshake, bank wrap, BCD conversion, overflow and reset abort.
module tb_io_port_ctrl;
    localparam int DATA_W = 32;
    localparam int IN_W   = 4;
    localparam int N_IN   = 2;
    localparam int DIGITS = 3;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 3;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           io_ctrl = 2'b00;
    logic [DATA_W-1:0]    io_addr = '0;
    logic [DATA_W-1:0]    wdata = '0;
    logic [N_IN*IN_W-1:0] sw_in = {4'h9, 4'h3};
    logic                 btn_in = 1'b0;
    logic [DATA_W-1:0]    rdata;
    logic                 io_stall;
    logic [DIGITS*4-1:0]  bcd;
    logic                 disp_busy;
    logic                 disp_ovf;

    int checks = 0;
    int passed = 0;
    logic [DATA_W-1:0] rd_model = '0;

    io_port_ctrl #(.DATA_W(DATA_W), .IN_W(IN_W), .N_IN(N_IN), .DIGITS(DIGITS), .DEBOUNCE(16)) dut (
        .clk(clk), .rst_n(rst_n), .io_ctrl(io_ctrl), .io_addr(io_addr), .wdata(wdata),
        .sw_in(sw_in), .btn_in(btn_in), .rdata(rdata), .io_stall(io_stall), .bcd(bcd),
        .disp_busy(disp_busy), .disp_ovf(disp_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        io_ctrl = 2'b10;
        tick(2);
        checks++; if (io_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", io_stall); else passed++;
        checks++; if (rdata !== '0) $display("FAIL reset_rdata: got %h expected 0", rdata); else passed++;
        checks++; if (bcd !== 12'h000) $display("FAIL reset_bcd: got %h expected 000", bcd); else passed++;
        checks++; if (disp_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", disp_busy); else passed++;
        checks++; if (disp_ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", disp_ovf); else passed++;
        io_ctrl = 2'b00;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_read(input logic [DATA_W-1:0] addr, input logic [3:0] exp_v);
        logic [DATA_W-1:0] exp_r;
        exp_r = {28'b0, exp_v};
        io_addr = addr;
        io_ctrl = 2'b10;
        #1;
        checks++; if (io_stall !== 1'b1) $display("FAIL read_stall_comb addr=%0d: got %b expected 1", addr, io_stall); else passed++;
        tick(3);
        checks++; if (io_stall !== 1'b1) $display("FAIL read_stall_wait addr=%0d: got %b expected 1", addr, io_stall); else passed++;
        btn_in = 1'b1;
        tick(LAT - 1);
        checks++; if (io_stall !== 1'b1) $display("FAIL read_stall_pre addr=%0d: got %b expected 1", addr, io_stall); else passed++;
        checks++; if (rdata !== rd_model) $display("FAIL read_rdata_pre addr=%0d: got %h expected %h", addr, rdata, rd_model); else passed++;
        tick(1);
        checks++; if (rdata !== exp_r) $display("FAIL read_rdata addr=%0d: got %h expected %h", addr, rdata, exp_r); else passed++;
        checks++; if (io_stall !== 1'b0) $display("FAIL read_stall_done addr=%0d: got %b expected 0", addr, io_stall); else passed++;
        rd_model = exp_r;
        io_ctrl = 2'b00;
        btn_in = 1'b0;
        tick(1);
        checks++; if (io_stall !== 1'b0) $display("FAIL read_stall_idle addr=%0d: got %b expected 0", addr, io_stall); else passed++;
        checks++; if (rdata !== exp_r) $display("FAIL read_rdata_hold addr=%0d: got %h expected %h", addr, rdata, exp_r); else passed++;
        tick(LAT + 2);
    endtask

    task automatic test_held_button();
        btn_in = 1'b1;
        tick(LAT + 5);
        io_addr = 32'd1;
        io_ctrl = 2'b10;
        tick(LAT + 5);
        checks++; if (io_stall !== 1'b1) $display("FAIL held_stall: got %b expected 1", io_stall); else passed++;
        checks++; if (rdata !== rd_model) $display("FAIL held_rdata: got %h expected %h", rdata, rd_model); else passed++;
        io_ctrl = 2'b11;
        tick(1);
        checks++; if (io_stall !== 1'b0) $display("FAIL abort_stall: got %b expected 0", io_stall); else passed++;
        tick(2);
        checks++; if (io_stall !== 1'b0) $display("FAIL ctrl11_stall: got %b expected 0", io_stall); else passed++;
        checks++; if (rdata !== rd_model) $display("FAIL abort_rdata: got %h expected %h", rdata, rd_model); else passed++;
        io_ctrl = 2'b00;
        btn_in = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_write_conv(input logic [DATA_W-1:0] val, input logic [11:0] exp_b, input logic [11:0] old_b);
        wdata = val;
        io_ctrl = 2'b01;
        #1;
        checks++; if (io_stall !== 1'b0) $display("FAIL write_nostall val=%0d: got %b expected 0", val, io_stall); else passed++;
        tick(1);
        io_ctrl = 2'b00;
        checks++; if (disp_busy !== 1'b1) $display("FAIL conv_busy_start val=%0d: got %b expected 1", val, disp_busy); else passed++;
        checks++; if (disp_ovf !== 1'b0) $display("FAIL conv_ovf val=%0d: got %b expected 0", val, disp_ovf); else passed++;
        tick(31);
        checks++; if (disp_busy !== 1'b1) $display("FAIL conv_busy_last val=%0d: got %b expected 1", val, disp_busy); else passed++;
        checks++; if (bcd !== old_b) $display("FAIL conv_bcd_old val=%0d: got %h expected %h", val, bcd, old_b); else passed++;
        tick(1);
        checks++; if (disp_busy !== 1'b0) $display("FAIL conv_busy_end val=%0d: got %b expected 0", val, disp_busy); else passed++;
        checks++; if (bcd !== exp_b) $display("FAIL conv_bcd val=%0d: got %h expected %h", val, bcd, exp_b); else passed++;
    endtask

    task automatic test_overflow(input logic [DATA_W-1:0] val);
        wdata = val;
        io_ctrl = 2'b01;
        tick(1);
        io_ctrl = 2'b00;
        checks++; if (disp_ovf !== 1'b1) $display("FAIL ovf_flag val=%0d: got %b expected 1", val, disp_ovf); else passed++;
        checks++; if (bcd !== 12'hFFF) $display("FAIL ovf_bcd val=%0d: got %h expected fff", val, bcd); else passed++;
        checks++; if (disp_busy !== 1'b0) $display("FAIL ovf_busy val=%0d: got %b expected 0", val, disp_busy); else passed++;
        tick(3);
        checks++; if (disp_busy !== 1'b0) $display("FAIL ovf_busy_later val=%0d: got %b expected 0", val, disp_busy); else passed++;
    endtask

    task automatic test_back_to_back();
        wdata = 32'd12;
        io_ctrl = 2'b01;
        tick(1);
        io_ctrl = 2'b00;
        tick(9);
        wdata = 32'd7;
        io_ctrl = 2'b01;
        tick(1);
        io_ctrl = 2'b00;
        checks++; if (disp_busy !== 1'b1) $display("FAIL restart_busy: got %b expected 1", disp_busy); else passed++;
        tick(31);
        checks++; if (disp_busy !== 1'b1) $display("FAIL restart_busy_last: got %b expected 1", disp_busy); else passed++;
        checks++; if (bcd !== 12'h999) $display("FAIL restart_bcd_old: got %h expected 999", bcd); else passed++;
        tick(1);
        checks++; if (disp_busy !== 1'b0) $display("FAIL restart_busy_end: got %b expected 0", disp_busy); else passed++;
        checks++; if (bcd !== 12'h007) $display("FAIL restart_bcd: got %h expected 007", bcd); else passed++;
    endtask

    task automatic test_ignored_ctrl();
        wdata = 32'd1000;
        io_ctrl = 2'b11;
        tick(2);
        io_ctrl = 2'b00;
        checks++; if (disp_ovf !== 1'b0) $display("FAIL ctrl11_ovf: got %b expected 0", disp_ovf); else passed++;
        checks++; if (bcd !== 12'h007) $display("FAIL ctrl11_bcd: got %h expected 007", bcd); else passed++;
        checks++; if (disp_busy !== 1'b0) $display("FAIL ctrl11_busy: got %b expected 0", disp_busy); else passed++;
    endtask

`ifdef IO_DEBOUNCE_EN
    task automatic test_debounce();
        io_addr = 32'd1;
        io_ctrl = 2'b10;
        tick(1);
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        tick(25);
        checks++; if (io_stall !== 1'b1) $display("FAIL glitch_stall: got %b expected 1", io_stall); else passed++;
        checks++; if (rdata !== rd_model) $display("FAIL glitch_rdata: got %h expected %h", rdata, rd_model); else passed++;
        btn_in = 1'b1;
        tick(LAT);
        checks++; if (rdata !== 32'h9) $display("FAIL debounce_rdata: got %h expected 00000009", rdata); else passed++;
        checks++; if (io_stall !== 1'b0) $display("FAIL debounce_stall: got %b expected 0", io_stall); else passed++;
        rd_model = 32'h9;
        io_ctrl = 2'b00;
        btn_in = 1'b0;
        tick(LAT + 2);
    endtask
`endif

    task automatic test_reset_mid();
        wdata = 32'd255;
        io_ctrl = 2'b01;
        tick(1);
        io_addr = 32'd0;
        io_ctrl = 2'b10;
        tick(3);
        checks++; if (io_stall !== 1'b1) $display("FAIL mid_stall: got %b expected 1", io_stall); else passed++;
        checks++; if (disp_busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", disp_busy); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (io_stall !== 1'b0) $display("FAIL rst_stall_async: got %b expected 0", io_stall); else passed++;
        checks++; if (disp_busy !== 1'b0) $display("FAIL rst_busy_async: got %b expected 0", disp_busy); else passed++;
        checks++; if (bcd !== 12'h000) $display("FAIL rst_bcd_async: got %h expected 000", bcd); else passed++;
        checks++; if (rdata !== '0) $display("FAIL rst_rdata_async: got %h expected 0", rdata); else passed++;
        io_ctrl = 2'b00;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        checks++; if (io_stall !== 1'b0) $display("FAIL post_rst_stall: got %b expected 0", io_stall); else passed++;
    endtask

    initial begin
        test_reset();
        test_read(32'd1, 4'h9);
        test_read(32'd0, 4'h3);
        test_read(32'd5, 4'h9);
        test_read(32'd2, 4'h3);
        test_held_button();
        test_write_conv(32'd255, 12'h255, 12'h000);
        test_overflow(32'd1000);
        test_overflow(32'hFFFF_FFFF);
        test_write_conv(32'd999, 12'h999, 12'hFFF);
        test_back_to_back();
        test_ignored_ctrl();
        test_write_conv(32'd0, 12'h000, 12'h007);
`ifdef IO_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

Parametrised processor I/O controller for the processor's input/output stage. It selects one of N_IN switch banks for input reads and holds the processor stalled until the user presses the confirm button. It latches written values into an output register and converts them with a sequential double-dabble engine into a DIGITS-wide BCD display bus. It sits between the datapath (address/write-data/read-data, 2-bit I/O control) and the board switches, button and 7-segment decoders.

## Interface
- DATA_W, 32, datapath width of wdata/rdata
- IN_W, 4, width of one switch bank
- N_IN, 2, number of switch banks (selected by io_addr)
- DIGITS, 3, BCD digits driven to the display
- DEBOUNCE, 16, stable cycles required on the button (only with IO_DEBOUNCE_EN)

- clk  in  1  single clock; all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- io_ctrl  in  2  00 idle, 01 write output, 10 read input, 11 reserved (treated as 00)
- io_addr  in  DATA_W  bank select = io_addr modulo N_IN (low clog2(N_IN) bits; bits ≥ N_IN wrap)
- wdata  in  DATA_W  value to display
- sw_in  in  N_IN*IN_W  switch banks, bank k at [k*IN_W +: IN_W]
- btn_in  in  1  raw confirm button, active-high, asynchronous to clk
- rdata  out  DATA_W  captured input, zero-extended
- io_stall  out  1  processor must hold its state while high
- bcd  out  DIGITS*4  display digits, digit 0 = units in [3:0]
- disp_busy  out  1  conversion in progress
- disp_ovf  out  1  last written value ≥ 10^DIGITS

## Operation
- Button path: 2-flop synchroniser → (optional debounce) → rising-edge pulse btn_evt.
- Read FSM, states IDLE, WAIT_BTN, DONE:
  - IDLE: io_ctrl==10 → WAIT_BTN; io_stall goes high combinationally in the same cycle.
  - WAIT_BTN: io_stall=1; on btn_evt capture rdata = {zeros, sw_in bank} → DONE.
  - DONE: io_stall=0, rdata stable; unconditionally → IDLE.
  - io_ctrl leaving 10 while in WAIT_BTN → IDLE, rdata unchanged.
  - Back-to-back reads require a fresh press; a held button never re-captures.
- Write/display FSM, states D_IDLE, D_CONV:
  - io_ctrl==01 in any state: latch wdata into out_reg.
  - If wdata ≥ 10^DIGITS: disp_ovf=1, bcd all digits 4'hF (blank), stay/return D_IDLE.
  - Else: disp_ovf=0, enter D_CONV with DATA_W shift/add-3 iterations; bcd updated atomically at the end; old bcd shown until then.
  - A write during D_CONV restarts the conversion with the new value.
- Writes never stall the processor; io_stall is read-only.
- Read and write FSMs are independent; 11 and 00 have no effect.

## Timing
- Reset values: rdata=0, io_stall=0, bcd=0, disp_busy=0, disp_ovf=0, both FSMs idle, synchroniser/debounce cleared.
- Read latency: 2 synchroniser cycles (+DEBOUNCE with macro) + 1 edge cycle after the press; rdata valid in the DONE cycle and thereafter.
- Conversion: disp_busy high for exactly DATA_W cycles starting the cycle after the write; bcd valid on the cycle disp_busy falls.
- Overflow path: bcd/disp_ovf update the cycle after the write, disp_busy stays 0.
- Reset mid-read or mid-conversion: all state aborts immediately; io_stall drops asynchronously.

## Configuration
- IO_DEBOUNCE_EN defined: the synchronised button must be stable high for DEBOUNCE consecutive cycles before btn_evt; glitches restart the counter.
- Undefined: btn_evt is a rising edge of the 2-flop synchronised button; no counter logic is instantiated.

## Test plan
- Read bank 1, sw_in={4'h9, 4'h3}, io_addr=1, press → io_stall high until capture, rdata=32'h9, stall low one cycle later.
- io_addr=5 with N_IN=2 → bank 1 selected (wrap); io_addr=0 → rdata=32'h3.
- Write wdata=255 → disp_busy 32 cycles, then bcd=12'h255, disp_ovf=0.
- Write 1000 → next cycle disp_ovf=1, bcd=12'hFFF, disp_busy=0.
- Write 12, then write 7 at conversion cycle 10 → final bcd=12'h007, busy spans 32 cycles after the second write.
- With IO_DEBOUNCE_EN: 3-cycle glitch on btn_in → no capture; clean press → capture; assert rst_n=0 during WAIT_BTN → io_stall 0 immediately.
